// File: rtl/button_event_arbiter.sv
// Press / long-press detector for N debounced buttons, serialising pending
// events onto a single valid/ready stream with round-robin arbitration.
module button_event_arbiter #(
    parameter int N           = 4,
    parameter int LONG_CYCLES = 200
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N-1:0]           btn,
    output logic                   ev_valid,
    input  logic                   ev_ready,
    output logic [$clog2(N)-1:0]   ev_id,
    output logic                   ev_long,
    output logic                   overrun
);

    localparam int          IDW       = $clog2(N);
    localparam logic [15:0] HOLD_MAX  = 16'(LONG_CYCLES);
    localparam logic [15:0] LFIRE_AT  = 16'(LONG_CYCLES - 1);

    logic [N-1:0]   btn_d_q, btn_d_d;
    logic [15:0]    hold_q [N];
    logic [15:0]    hold_d [N];
    logic [N-1:0]   spend_q, spend_d;
    logic [N-1:0]   lpend_q, lpend_d;
    logic [IDW-1:0] ptr_q, ptr_d;
    logic           ev_valid_q, ev_valid_d;
    logic [IDW-1:0] ev_id_q, ev_id_d;
    logic           ev_long_q, ev_long_d;
    logic           overrun_q, overrun_d;

    logic [N-1:0]   press, lfire, pend, clr_s, clr_l;
    logic           load, found;
    int             gnt_idx, scan_idx;

    // NOTE: every variable written here gets a default first, so no path can infer a latch.
    always_comb begin
        btn_d_d   = btn;
        press     = btn & ~btn_d_q;
        lfire     = '0;
        for (int i = 0; i < N; i++) begin
            hold_d[i] = hold_q[i];
            lfire[i]  = btn[i] & btn_d_q[i] & (hold_q[i] == LFIRE_AT);
            if (press[i] || !btn[i]) begin
                hold_d[i] = '0;
            end else if (hold_q[i] < HOLD_MAX) begin
                hold_d[i] = hold_q[i] + 16'd1;
            end
        end

        // Round-robin scan over the pre-edge pending flags, starting at ptr.
        load     = ~ev_valid_q | ev_ready;
        pend     = spend_q | lpend_q;
        found    = 1'b0;
        gnt_idx  = 0;
        scan_idx = 0;
        for (int off = 0; off < N; off++) begin
            scan_idx = (int'(ptr_q) + off) % N;
            if (!found && pend[scan_idx]) begin
                found   = 1'b1;
                gnt_idx = scan_idx;
            end
        end

        clr_s      = '0;
        clr_l      = '0;
        ptr_d      = ptr_q;
        ev_valid_d = ev_valid_q;
        ev_id_d    = ev_id_q;
        ev_long_d  = ev_long_q;
        if (load) begin
            if (found) begin
                ev_valid_d = 1'b1;
                ev_id_d    = IDW'(gnt_idx);
                ptr_d      = IDW'((gnt_idx + 1) % N);
                if (spend_q[gnt_idx]) begin
                    clr_s[gnt_idx] = 1'b1;
                    ev_long_d      = 1'b0;
                end else begin
                    clr_l[gnt_idx] = 1'b1;
                    ev_long_d      = 1'b1;
                end
            end else begin
                ev_valid_d = 1'b0;
            end
        end

        // A set landing on a flag that is being granted away re-arms it silently.
        spend_d   = (spend_q & ~clr_s) | press;
        lpend_d   = (lpend_q & ~clr_l) | lfire;
        overrun_d = (|(press & spend_q & ~clr_s)) | (|(lfire & lpend_q & ~clr_l));
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            btn_d_q    <= '0;
            spend_q    <= '0;
            lpend_q    <= '0;
            ptr_q      <= '0;
            ev_valid_q <= 1'b0;
            ev_id_q    <= '0;
            ev_long_q  <= 1'b0;
            overrun_q  <= 1'b0;
            // NOTE: the hold counters are a small register array, so they are reset like any flop.
            for (int i = 0; i < N; i++) begin
                hold_q[i] <= '0;
            end
        end else begin
            btn_d_q    <= btn_d_d;
            spend_q    <= spend_d;
            lpend_q    <= lpend_d;
            ptr_q      <= ptr_d;
            ev_valid_q <= ev_valid_d;
            ev_id_q    <= ev_id_d;
            ev_long_q  <= ev_long_d;
            overrun_q  <= overrun_d;
            for (int i = 0; i < N; i++) begin
                hold_q[i] <= hold_d[i];
            end
        end
    end

    assign ev_valid = ev_valid_q;
    assign ev_id    = ev_id_q;
    assign ev_long  = ev_long_q;
    assign overrun  = overrun_q;

endmodule

// File: tb/tb_button_event_arbiter.sv
// Directed bench for button_event_arbiter: a cycle-level event model checked
// every cycle, plus hand-computed expectations for each scenario.
module tb_button_event_arbiter;

    localparam int N = 4;
    localparam int L = 20;

    logic         clk = 1'b0;
    logic         rst;
    logic [N-1:0] btn;
    logic         ev_valid;
    logic         ev_ready;
    logic [1:0]   ev_id;
    logic         ev_long;
    logic         overrun;

    button_event_arbiter #(.N(N), .LONG_CYCLES(L)) dut (
        .clk      (clk),
        .rst      (rst),
        .btn      (btn),
        .ev_valid (ev_valid),
        .ev_ready (ev_ready),
        .ev_id    (ev_id),
        .ev_long  (ev_long),
        .overrun  (overrun)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Accepted events as seen on the DUT port, stamped with the edge number.
    typedef struct {
        int cyc;
        int id;
        int lng;
    } ev_t;
    ev_t log_q[$];
    int  cyc_cnt = 0;
    int  ov_cnt  = 0;

    // Model state: what is pending, how long each button has been held,
    // and what the output register must show.
    bit m_prev [N];
    int m_age  [N];
    bit m_sp   [N];
    bit m_lp   [N];
    int m_ptr;
    bit m_valid;
    int m_id;
    bit m_long;
    bit m_ov;

    bit pr [N];
    bit lf [N];
    bit ld, fnd, ov, gs, gl;
    int g, j;

    always @(posedge clk) begin
        cyc_cnt++;
        if (!rst && ev_valid && ev_ready)
            log_q.push_back('{cyc: cyc_cnt, id: int'(ev_id), lng: int'(ev_long)});

        if (rst) begin
            for (int i = 0; i < N; i++) begin
                m_prev[i] = 0; m_age[i] = 0; m_sp[i] = 0; m_lp[i] = 0;
            end
            m_ptr = 0; m_valid = 0; m_id = 0; m_long = 0; m_ov = 0;
        end else begin
            // A long event fires on the L-th edge after the press edge, held throughout.
            for (int i = 0; i < N; i++) begin
                pr[i] = btn[i] && !m_prev[i];
                lf[i] = 0;
                if (pr[i]) begin
                    m_age[i] = 0;
                end else if (btn[i] && m_prev[i]) begin
                    m_age[i]++;
                    lf[i] = (m_age[i] == L);
                end else begin
                    m_age[i] = 0;
                end
                m_prev[i] = btn[i];
            end

            ld  = !m_valid || ev_ready;
            fnd = 0;
            g   = 0;
            if (ld) begin
                for (int off = 0; off < N; off++) begin
                    j = (m_ptr + off) % N;
                    if (!fnd && (m_sp[j] || m_lp[j])) begin
                        fnd = 1;
                        g   = j;
                    end
                end
            end

            ov = 0;
            if (ld && fnd) begin
                m_valid = 1;
                m_id    = g;
                m_long  = !m_sp[g];
                m_ptr   = (g + 1) % N;
            end else if (ld) begin
                m_valid = 0;
            end
            for (int i = 0; i < N; i++) begin
                gs = ld && fnd && (g == i) && m_sp[i];
                gl = ld && fnd && (g == i) && !m_sp[i];
                if (pr[i] && m_sp[i] && !gs) ov = 1;
                if (lf[i] && m_lp[i] && !gl) ov = 1;
                m_sp[i] = (m_sp[i] && !gs) || pr[i];
                m_lp[i] = (m_lp[i] && !gl) || lf[i];
            end
            m_ov = ov;
        end
    end

    always @(negedge clk) begin
        check("cyc_valid", ev_valid, m_valid);
        check("cyc_overrun", overrun, m_ov);
        if (m_valid) begin
            check("cyc_id", ev_id, m_id);
            check("cyc_long", ev_long, m_long);
        end
        if (overrun) ov_cnt++;
    end

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    function automatic int count_ev(input int id, input int lng);
        int c = 0;
        foreach (log_q[k]) if (log_q[k].id == id && log_q[k].lng == lng) c++;
        return c;
    endfunction

    initial begin
        rst = 1'b1; btn = '0; ev_ready = 1'b1;
        wait_cyc(3);
        check("rst_valid", ev_valid, 0);
        check("rst_id", ev_id, 0);
        check("rst_long", ev_long, 0);
        check("rst_overrun", overrun, 0);
        rst = 1'b0;
        wait_cyc(2);

        // Single short press: visible two edges after the rise, no long event.
        log_q.delete();
        btn = 4'b0001;
        wait_cyc(1);
        check("t1_not_yet", ev_valid, 0);
        wait_cyc(1);
        check("t1_valid", ev_valid, 1);
        check("t1_id", ev_id, 0);
        check("t1_long", ev_long, 0);
        wait_cyc(8);
        btn = '0;
        wait_cyc(30);
        check("t1_events", log_q.size(), 1);
        check("t1_no_long", count_ev(0, 1), 0);

        // Long press: press then one long event, L edges apart.
        log_q.delete();
        btn = 4'b0100;
        wait_cyc(30);
        btn = '0;
        wait_cyc(5);
        check("t2_events", log_q.size(), 2);
        check("t2_first_id", log_q[0].id, 2);
        check("t2_first_long", log_q[0].lng, 0);
        check("t2_second_id", log_q[1].id, 2);
        check("t2_second_long", log_q[1].lng, 1);
        check("t2_gap", log_q[1].cyc - log_q[0].cyc, L);

        // Round-robin from ptr=0 after a reset.
        rst = 1'b1;
        wait_cyc(1);
        rst = 1'b0;
        wait_cyc(2);
        log_q.delete();
        btn = 4'b1111;
        wait_cyc(8);
        btn = '0;
        wait_cyc(4);
        check("t3_events", log_q.size(), 4);
        for (int k = 0; k < 4; k++) check("t3_order", log_q[k].id, k);
        for (int k = 1; k < 4; k++) check("t3_b2b", log_q[k].cyc - log_q[k-1].cyc, 1);
        log_q.delete();
        btn = 4'b1010;
        wait_cyc(6);
        btn = '0;
        wait_cyc(4);
        check("t3b_events", log_q.size(), 2);
        check("t3b_first", log_q[0].id, 1);
        check("t3b_second", log_q[1].id, 3);

        // Backpressure and overrun on a second press of button 1.
        log_q.delete();
        ov_cnt   = 0;
        ev_ready = 1'b0;
        btn      = 4'b0011;
        wait_cyc(3);
        check("t4_stall_valid", ev_valid, 1);
        check("t4_stall_id", ev_id, 0);
        btn = 4'b0001;
        wait_cyc(2);
        btn = 4'b0011;
        wait_cyc(3);
        check("t4_stall_id2", ev_id, 0);
        btn = '0;
        wait_cyc(2);
        check("t4_overrun", ov_cnt, 1);
        ev_ready = 1'b1;
        wait_cyc(6);
        check("t4_events", log_q.size(), 2);
        check("t4_id1_once", count_ev(1, 0), 1);

        // Reset with an event in flight and button 3 held through it.
        ev_ready = 1'b0;
        btn      = 4'b0001;
        wait_cyc(2);
        btn = 4'b0000;
        wait_cyc(1);
        btn = 4'b1000;
        wait_cyc(3);
        rst = 1'b1;
        wait_cyc(1);
        check("t5_valid", ev_valid, 0);
        check("t5_id", ev_id, 0);
        check("t5_long", ev_long, 0);
        check("t5_overrun", overrun, 0);
        rst      = 1'b0;
        ev_ready = 1'b1;
        log_q.delete();
        wait_cyc(1);
        check("t5_not_yet", ev_valid, 0);
        wait_cyc(1);
        check("t5_press_valid", ev_valid, 1);
        check("t5_press_id", ev_id, 3);
        check("t5_press_long", ev_long, 0);
        wait_cyc(5);
        btn = '0;
        wait_cyc(4);
        check("t5_events", log_q.size(), 1);

        // Button 0 re-pressed on the very edge its pending press is granted.
        log_q.delete();
        ov_cnt   = 0;
        ev_ready = 1'b0;
        btn      = 4'b1000;
        wait_cyc(3);
        btn = 4'b1001;
        wait_cyc(2);
        btn = 4'b1000;
        wait_cyc(2);
        btn      = 4'b1001;
        ev_ready = 1'b1;
        wait_cyc(3);
        btn = '0;
        wait_cyc(5);
        check("t6_events", log_q.size(), 3);
        check("t6_first", log_q[0].id, 3);
        check("t6_second", log_q[1].id, 0);
        check("t6_third", log_q[2].id, 0);
        check("t6_no_overrun", ov_cnt, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
